// File: rtl/btb_update_ctrl.sv
// Write-side controller for the 512-entry BTB: queues resolved branches and
// read-modify-writes their entries with S/V hysteresis, plus a full-array clear sweep.
module btb_update_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_W      = 9,
  parameter int TAG_W      = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             res_valid,
  input  logic [15:0]      res_pc,
  input  logic             res_taken,
  input  logic [15:0]      res_target,
  output logic             res_ready,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             mem_rd_en,
  output logic [IDX_W-1:0] mem_rd_idx,
  input  logic [25:0]      mem_rd_data,
  output logic             mem_wr_en,
  output logic [IDX_W-1:0] mem_wr_idx,
  output logic [25:0]      mem_wr_data
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int TAGH = TAG_W + 17;  // top tag bit; bits above it are always zero

  typedef struct packed {
    logic [15:0] pc;
    logic        taken;
    logic [15:0] tgt;
  } res_t;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CMP, S_WR, S_CLEAR} state_t;

  state_t            r_state, w_next;
  res_t              r_fifo [FIFO_DEPTH];
  logic [PW-1:0]     r_wp, r_rp;
  logic [PW:0]       r_cnt;
  res_t              r_work;
  logic [IDX_W-1:0]  r_wr_idx;
  logic [25:0]       r_wr_data;
  logic [IDX_W-1:0]  r_clr_cnt;
  logic              r_clr_pend;

  logic              w_full, w_empty, w_push, w_pop;
  res_t              w_in;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit, w_do_wr;
  logic [25:0]       w_new;

  assign w_full  = (r_cnt == (PW+1)'(FIFO_DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_push  = res_valid && res_ready;
  assign w_pop   = (r_state == S_IDLE) && !r_clr_pend && !w_empty;
  assign w_in    = '{pc: res_pc, taken: res_taken, tgt: res_target};

  // ---------------- resolved-branch FIFO ----------------
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wp] <= w_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // ---------------- entry update policy ----------------
  always_comb begin
    w_tag = r_work.pc[15:IDX_W];
    w_hit = mem_rd_data[16] && (mem_rd_data[TAGH:18] == w_tag);
    w_new = '0;
    w_new[TAGH:0] = mem_rd_data[TAGH:0];
    if (w_hit) begin
      if (r_work.taken) begin
        if (mem_rd_data[15:0] == r_work.tgt) w_new[17] = 1'b1;
        else if (mem_rd_data[17])            w_new[17] = 1'b0;
        else                                 w_new[15:0] = r_work.tgt;
      end else begin
        if (mem_rd_data[17]) w_new[17] = 1'b0;
        else                 w_new[16] = 1'b0;
      end
    end else if (r_work.taken) begin
      w_new            = '0;
      w_new[TAGH:18]   = w_tag;
      w_new[16]        = 1'b1;
      w_new[15:0]      = r_work.tgt;
    end
    w_do_wr = (w_hit || r_work.taken) && (w_new != mem_rd_data);
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_clr_pend) w_next = S_CLEAR;
               else if (!w_empty) w_next = S_RD;
      S_RD:    w_next = S_CMP;
      S_CMP:   w_next = w_do_wr ? S_WR : S_IDLE;
      S_WR:    w_next = S_IDLE;
      S_CLEAR: if (r_clr_cnt == '1) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    clr_busy    = r_clr_pend || (r_state == S_CLEAR);
    res_ready   = !w_full && !clr_busy;
    mem_rd_en   = 1'b0;
    mem_rd_idx  = '0;
    mem_wr_en   = 1'b0;
    mem_wr_idx  = '0;
    mem_wr_data = '0;
    case (r_state)
      S_RD: begin
        mem_rd_en  = 1'b1;
        mem_rd_idx = r_work.pc[IDX_W-1:0];
      end
      S_WR: begin
        mem_wr_en   = 1'b1;
        mem_wr_idx  = r_wr_idx;
        mem_wr_data = r_wr_data;
      end
      S_CLEAR: begin
        mem_wr_en  = 1'b1;
        mem_wr_idx = r_clr_cnt;
      end
      default: ;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work     <= '0;
      r_wr_idx   <= '0;
      r_wr_data  <= '0;
      r_clr_cnt  <= '0;
      r_clr_pend <= 1'b0;
    end else begin
      if (w_pop) r_work <= r_fifo[r_rp];
      if (r_state == S_CMP && w_do_wr) begin
        r_wr_idx  <= r_work.pc[IDX_W-1:0];
        r_wr_data <= w_new;
      end
      if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
      // The pending flag hands over to the CLEAR state; requests during the sweep are dropped.
      if (r_state == S_IDLE && r_clr_pend)           r_clr_pend <= 1'b0;
      else if (clr_req && r_state != S_CLEAR)        r_clr_pend <= 1'b1;
    end
  end

endmodule

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
Write-side controller for the 512-entry branch target buffer; the fetch-side lookup reads the same array.
- Accepts resolved-branch records from the execute stage into a small FIFO.
- Performs read-modify-write on the BTB entry indexed by PC[8:0], applying the strong/valid hysteresis policy.
- Provides a full-array invalidate sweep.
- Entry format, 26 bits: tag[24:18] = PC[15:9], S[17], V[16], target[15:0]. Bits [25] are always written 0.

Parameters:
FIFO_DEPTH, 4, resolved-branch FIFO entries (power of 2, >=2)
IDX_W, 9, BTB index width (512 entries)
TAG_W, 7, tag width = 16 - IDX_W

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  reset, asynchronous, active-low
res_valid  in  1  resolved-branch record valid
res_pc  in  16  PC of resolved branch
res_taken  in  1  branch resolved taken
res_target  in  16  resolved target PC
res_ready  out  1  FIFO can accept; push = res_valid && res_ready
clr_req  in  1  single-cycle pulse: invalidate whole BTB
clr_busy  out  1  clear pending or in progress
mem_rd_en  out  1  BTB read strobe
mem_rd_idx  out  IDX_W  read index
mem_rd_data  in  26  entry; valid the cycle after mem_rd_en
mem_wr_en  out  1  BTB write strobe
mem_wr_idx  out  IDX_W  write index
mem_wr_data  out  26  entry written

Behaviour:
Reset:
- FIFO empty, state IDLE, clear-pending flag 0, clear counter 0.
- mem_rd_en, mem_wr_en, clr_busy = 0; indices and data = 0.
- res_ready = 1.
- BTB contents are not touched by reset.

FIFO:
- res_ready = !full && !clr_busy.
- Push and pop in the same cycle are legal when neither full nor empty; occupancy is unchanged.
- Records are processed strictly in order.

FSM states: IDLE, RD, CMP, WR, CLEAR.
- IDLE:
  - If clear is pending, go to CLEAR. Clear has priority over the FIFO.
  - Else if FIFO is non-empty, pop the head into the working register and go to RD.
- RD: mem_rd_en = 1, mem_rd_idx = work_pc[8:0]; go to CMP.
- CMP: sample mem_rd_data and compute the new entry.
  - hit = V && tag == work_pc[15:9].
  - If new entry differs from old, register it and go to WR; else return to IDLE (no write).
- WR: mem_wr_en = 1 for exactly one cycle with registered idx/data; go to IDLE.
- Per-record latency: 3 cycles (pop -> write), or 2 cycles with no write. Back-to-back records are serialized, so no read-after-write hazard.

Update policy:
- hit, taken, target equal: S = 1.
- hit, taken, target differs:
  - S = 1: S = 0, keep old target.
  - S = 0: target = res_target, S = 0.
- hit, not taken:
  - S = 1: S = 0.
  - S = 0: V = 0, other fields unchanged.
- miss, taken: allocate {tag, S=0, V=1, target}, replacing any existing entry.
- miss, not taken: no write.

Clear:
- clr_req sets the pending flag in any state. clr_busy rises the next cycle and stays high through CLEAR.
- An in-flight RMW (RD/CMP/WR) completes first.
- CLEAR writes 26'h0 to index 0..511, one per cycle (512 cycles, mem_wr_en high throughout).
- On the last index: return to IDLE; clr_busy drops the following cycle.
- FIFO contents are retained and processed after the clear.
- A clr_req during CLEAR is ignored.

Reset mid-operation: returns immediately to the reset state. A partially swept array is acceptable; software reissues the clear.

Test Plan:
- Reset, then push {pc=16'h1234, taken, tgt=16'h2000} into an empty BTB -> read idx 0x034; write idx 0x034, data {tag 7'h09, S0, V1, 16'h2000} exactly 3 cycles after the pop.
- Same record again -> write with S=1. Third identical record -> no mem_wr_en (entry unchanged).
- Entry S=1, then not-taken -> S=0. Not-taken again -> V=0. Not-taken on the miss -> no write.
- Entry S=0 tgt 16'h2000, taken tgt 16'h3000 -> target replaced. With S=1, same stimulus -> target kept, S cleared.
- Push 5 records with the FSM stalled on its first -> res_ready drops at 4 buffered. All five are processed in order; the ready/valid stall is observed.
- clr_req while in CMP -> pending RMW write completes, then 512 consecutive zero writes idx 0..511. res_ready = 0 and clr_busy = 1 throughout; the queued record is processed afterwards.
